// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// slave: the LSU side; master: the pipeline and memory side.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic              mem_sb;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_fault,
    output mem_addr, mem_wdata, mem_write, mem_sb
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_fault,
    input  mem_addr, mem_wdata, mem_write, mem_sb
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed data memory; SH is issued as two SB writes.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned H/HU/W accesses instead of completing them.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  lsu
);

  typedef enum logic [1:0] {IDLE, ACCESS, SH_HI, DONE} state_t;

  state_t            state, state_nxt;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic [ADDR_W:0]   size_m1;
  logic [ADDR_W:0]   last_byte;
  logic              illegal, range_fault, misalign, req_fault;
  logic [31:0]       ext_data;
  logic              mem_we;

  // One extra address bit so addr + size - 1 cannot wrap past the top.
  always_comb begin
    case (lsu.req_funct3[1:0])
      2'b00:   size_m1 = (ADDR_W+1)'(0);
      2'b01:   size_m1 = (ADDR_W+1)'(1);
      default: size_m1 = (ADDR_W+1)'(3);
    endcase
    last_byte   = {1'b0, lsu.req_addr} + size_m1;
    range_fault = last_byte >= (ADDR_W+1)'(MEM_BYTES);
    illegal     = (lsu.req_funct3 == 3'b011) || (lsu.req_funct3[2:1] == 2'b11) ||
                  (lsu.req_store && lsu.req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign    = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                  ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
`else
    misalign    = 1'b0;
`endif
    req_fault   = illegal || range_fault || misalign;
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext_data = {{24{lsu.mem_rdata[7]}}, lsu.mem_rdata[7:0]};
      3'b001:  ext_data = {{16{lsu.mem_rdata[15]}}, lsu.mem_rdata[15:0]};
      3'b100:  ext_data = {24'b0, lsu.mem_rdata[7:0]};
      3'b101:  ext_data = {16'b0, lsu.mem_rdata[15:0]};
      default: ext_data = lsu.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && lsu.req_valid) begin
        store_q  <= lsu.req_store;
        funct3_q <= lsu.req_funct3;
        addr_q   <= lsu.req_addr;
        wdata_q  <= lsu.req_wdata;
        fault_q  <= req_fault;
        rdata_q  <= '0;
      end else if (state == ACCESS && !store_q) begin
        rdata_q  <= ext_data;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    lsu.req_ready  = 1'b0;
    lsu.resp_valid = 1'b0;
    lsu.mem_addr   = '0;
    lsu.mem_wdata  = '0;
    lsu.mem_sb     = 1'b0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) state_nxt = req_fault ? DONE : ACCESS;
      end
      ACCESS: begin
        lsu.mem_addr = addr_q;
        if (store_q) begin
          mem_we        = 1'b1;
          lsu.mem_sb    = (funct3_q[1:0] != 2'b10);
          lsu.mem_wdata = wdata_q;
        end
        state_nxt = (store_q && funct3_q[1:0] == 2'b01) ? SH_HI : DONE;
      end
      SH_HI: begin
        lsu.mem_addr  = addr_q + ADDR_W'(1);
        lsu.mem_wdata = {24'b0, wdata_q[15:8]};
        lsu.mem_sb    = 1'b1;
        mem_we        = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        lsu.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Level-sensitive memory: the write strobe must fall in the same cycle reset rises.
  assign lsu.mem_write  = mem_we & ~reset;
  assign lsu.resp_data  = rdata_q;
  assign lsu.resp_fault = fault_q & (state == DONE);

endmodule
